// File: rtl/mem_bus_sequencer_if.sv
// Bundle of the CPU-side request/response signals and the shared pad bus
// pins handled by mem_bus_sequencer. The slave modport is the sequencer's
// view. The master modport is the surrounding logic: the core's request
// port plus the pad/strobe wiring.
interface mem_bus_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [7:0]  pad_out;
    logic [7:0]  pad_oe;
    logic [7:0]  pad_in;
    logic        mar_we;
    logic        addr_hi;
    logic        ram_we;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, pad_in,
        output req_ready, rsp_valid, rsp_rdata, pad_out, pad_oe,
               mar_we, addr_hi, ram_we
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, pad_in,
        input  req_ready, rsp_valid, rsp_rdata, pad_out, pad_oe,
               mar_we, addr_hi, ram_we
    );
endinterface

// File: rtl/mem_bus_sequencer.sv
// Sequences one CPU memory request onto the shared 8-bit pad bus.
// A write goes out as: address high byte, address low byte, data.
// A read goes out as: address high byte, address low byte, then the bus is
// released for WAIT_CYCLES, and after that one response cycle follows.
// Every output is a flop whose value is decided from the state being
// entered, so outputs only change on state-entry edges.
module mem_bus_sequencer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_sequencer_if.slave bus
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("mem_bus_sequencer: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        WRITE,
        RWAIT,
        RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] addr_reg, addr_next;
    logic        we_reg, we_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic [3:0]  cnt_reg, cnt_next;

    logic        ready_reg, ready_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [7:0]  rdata_reg, rdata_next;
    logic [7:0]  pad_out_reg, pad_out_next;
    logic [7:0]  pad_oe_reg, pad_oe_next;
    logic        mar_we_reg, mar_we_next;
    logic        addr_hi_reg, addr_hi_next;
    logic        ram_we_reg, ram_we_next;

    // Next state, request capture, wait counter, and the registered outputs
    // that belong to the state being entered.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        we_next        = we_reg;
        wdata_next     = wdata_reg;
        cnt_next       = cnt_reg;
        rdata_next     = rdata_reg;
        ready_next     = 1'b0;
        rsp_valid_next = 1'b0;
        pad_out_next   = 8'h00;
        pad_oe_next    = 8'h00;
        mar_we_next    = 1'b0;
        addr_hi_next   = 1'b0;
        ram_we_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = ADDR_H;
                    addr_next  = bus.req_addr;
                    we_next    = bus.req_we;
                    wdata_next = bus.req_wdata;
                end
            end
            ADDR_H: state_next = ADDR_L;
            ADDR_L: begin
                if (we_reg) begin
                    state_next = WRITE;
                end else begin
                    state_next = RWAIT;
                    cnt_next   = CNT_LOAD;
                end
            end
            WRITE:  state_next = RESP;
            RWAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    rdata_next = bus.pad_in;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // The address and data are taken from the *_next values. On the
        // accept edge the registers do not yet hold the new request.
        case (state_next)
            IDLE:   ready_next = 1'b1;
            ADDR_H: begin
                pad_out_next = addr_next[15:8];
                pad_oe_next  = 8'hFF;
                mar_we_next  = 1'b1;
                addr_hi_next = 1'b1;
            end
            ADDR_L: begin
                pad_out_next = addr_next[7:0];
                pad_oe_next  = 8'hFF;
                mar_we_next  = 1'b1;
            end
            WRITE: begin
                pad_out_next = wdata_next;
                pad_oe_next  = 8'hFF;
                ram_we_next  = 1'b1;
            end
            RESP:    rsp_valid_next = 1'b1;
            default: ;
        endcase
    end

    // State, captured request and output registers. An async reset drops
    // any access that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= 16'h0000;
            we_reg        <= 1'b0;
            wdata_reg     <= 8'h00;
            cnt_reg       <= 4'd0;
            ready_reg     <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rdata_reg     <= 8'h00;
            pad_out_reg   <= 8'h00;
            pad_oe_reg    <= 8'h00;
            mar_we_reg    <= 1'b0;
            addr_hi_reg   <= 1'b0;
            ram_we_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            we_reg        <= we_next;
            wdata_reg     <= wdata_next;
            cnt_reg       <= cnt_next;
            ready_reg     <= ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rdata_reg     <= rdata_next;
            pad_out_reg   <= pad_out_next;
            pad_oe_reg    <= pad_oe_next;
            mar_we_reg    <= mar_we_next;
            addr_hi_reg   <= addr_hi_next;
            ram_we_reg    <= ram_we_next;
        end
    end

    assign bus.req_ready = ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rdata_reg;
    assign bus.pad_out   = pad_out_reg;
    assign bus.pad_oe    = pad_oe_reg;
    assign bus.mar_we    = mar_we_reg;
    assign bus.addr_hi   = addr_hi_reg;
    assign bus.ram_we    = ram_we_reg;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench for mem_bus_sequencer. There are four instances, with
// WAIT_CYCLES of 2, 1, 15 and 3. They share clk and rst. A per-cycle
// vector table drives the WAIT_CYCLES=2 instance. Hand-written sequences
// cover reset in flight and the wait-length corners.
module tb_mem_bus_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_sequencer_if bus2 ();
    mem_bus_sequencer_if bus1 ();
    mem_bus_sequencer_if bus15 ();
    mem_bus_sequencer_if bus3 ();

    mem_bus_sequencer #(.WAIT_CYCLES(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
    mem_bus_sequencer #(.WAIT_CYCLES(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    mem_bus_sequencer #(.WAIT_CYCLES(15)) dut15 (.clk(clk), .rst(rst), .bus(bus15));
    mem_bus_sequencer #(.WAIT_CYCLES(3))  dut3  (.clk(clk), .rst(rst), .bus(bus3));

    int checks = 0;
    int errors = 0;

    // Observed output vector: {pad_out, pad_oe, mar_we, addr_hi, ram_we, req_ready, rsp_valid, rsp_rdata}
    logic [28:0] obs2;
    assign obs2 = {bus2.pad_out, bus2.pad_oe, bus2.mar_we, bus2.addr_hi, bus2.ram_we,
                   bus2.req_ready, bus2.rsp_valid, bus2.rsp_rdata};

    logic [3:0] rsp_v;
    assign rsp_v = {bus3.rsp_valid, bus15.rsp_valid, bus1.rsp_valid, bus2.rsp_valid};

    typedef struct {
        logic        vld;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  pin;
        logic [28:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic vld, input logic we, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [7:0] pin,
                       input logic [7:0] out, input logic [7:0] oe, input logic mar,
                       input logic hi, input logic ram, input logic rdy,
                       input logic rsp, input logic [7:0] rd);
        vec_t v;
        v.vld  = vld;
        v.we   = we;
        v.addr = addr;
        v.wd   = wd;
        v.pin  = pin;
        v.exp  = {out, oe, mar, hi, ram, rdy, rsp, rd};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Wait for a response pulse on instance k and report its cycle number.
    // The caller drives the request in cycle 0. A value of 99 means no
    // response came within 40 cycles.
    task automatic wait_rsp(input int k, output int lat);
        lat = 99;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus1.req_valid  = 1'b0;
            bus2.req_valid  = 1'b0;
            bus3.req_valid  = 1'b0;
            bus15.req_valid = 1'b0;
            if (rsp_v[k]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic watch_quiet(input int k, input string name);
        int hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_v[k]) hits++;
        end
        check(name, hits, 0);
    endtask

    // The two strobes must never be high together on the main instance.
    always @(negedge clk) begin
        if (!rst && bus2.mar_we && bus2.ram_we) begin
            errors++;
            $display("FAIL strobe_overlap mar_we=%b ram_we=%b required not both 1",
                     bus2.mar_we, bus2.ram_we);
        end
    end

    initial begin
        int lat;
        rst = 1'b1;
        bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = 0; bus1.req_wdata = 0; bus1.pad_in = 0;
        bus2.req_valid = 0; bus2.req_we = 0; bus2.req_addr = 0; bus2.req_wdata = 0; bus2.pad_in = 0;
        bus3.req_valid = 0; bus3.req_we = 0; bus3.req_addr = 0; bus3.req_wdata = 0; bus3.pad_in = 0;
        bus15.req_valid = 0; bus15.req_we = 0; bus15.req_addr = 0; bus15.req_wdata = 0; bus15.pad_in = 0;

        //   vld we addr     wd     pin   | out    oe     mar  hi   ram  rdy  rsp  rd
        // write 0x12AB <- 0x5C
        add(1, 1, 16'h12AB, 8'h5C, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'h12, 8'hFF, 1, 1, 0, 0, 0, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'hAB, 8'hFF, 1, 0, 0, 0, 0, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'h5C, 8'hFF, 0, 0, 1, 0, 0, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h00);
        // read 0x00F0: pad_in FF in cycle 3, 3C in cycle 4
        add(1, 0, 16'h00F0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 1, 0, 0, 0, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'hF0, 8'hFF, 1, 0, 0, 0, 0, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 8'h3C, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h3C);
        // held req_valid; address/data change to 0xBEEF/0x88 while busy
        add(1, 1, 16'h1234, 8'h77, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h3C);
        add(1, 1, 16'hBEEF, 8'h88, 8'h00, 8'h12, 8'hFF, 1, 1, 0, 0, 0, 8'h3C);
        add(1, 1, 16'hBEEF, 8'h88, 8'h00, 8'h34, 8'hFF, 1, 0, 0, 0, 0, 8'h3C);
        add(1, 1, 16'hBEEF, 8'h88, 8'h00, 8'h77, 8'hFF, 0, 0, 1, 0, 0, 8'h3C);
        add(1, 1, 16'hBEEF, 8'h88, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h3C);
        add(1, 1, 16'hBEEF, 8'h88, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h3C);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'hBE, 8'hFF, 1, 1, 0, 0, 0, 8'h3C);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'hEF, 8'hFF, 1, 0, 0, 0, 0, 8'h3C);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'h88, 8'hFF, 0, 0, 1, 0, 0, 8'h3C);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 8'h3C);
        add(0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'h3C);

        // Reset state, checked while rst is still held.
        repeat (3) @(negedge clk);
        check("reset_state", obs2, {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
        rst = 1'b0;

        // Vector table: each row checks the outputs of one cycle and
        // drives the inputs for that cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check($sformatf("vec%0d", i), obs2, vecs[i].exp);
            bus2.req_valid = vecs[i].vld;
            bus2.req_we    = vecs[i].we;
            bus2.req_addr  = vecs[i].addr;
            bus2.req_wdata = vecs[i].wd;
            bus2.pad_in    = vecs[i].pin;
        end

        // Async reset during ADDR_L of a write.
        @(negedge clk);
        bus2.req_valid = 1; bus2.req_we = 1; bus2.req_addr = 16'h4321; bus2.req_wdata = 8'h11;
        @(negedge clk);
        bus2.req_valid = 0;
        @(negedge clk);
        check("addrl_before_rst", {bus2.pad_out, bus2.mar_we}, {8'h21, 1'b1});
        #2 rst = 1'b1;
        #1 check("rst_addrl_async", {bus2.pad_oe, bus2.mar_we, bus2.req_ready}, {8'h00, 1'b0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        watch_quiet(0, "rst_addrl_no_rsp");
        @(negedge clk);
        bus2.req_valid = 1; bus2.req_we = 0; bus2.req_addr = 16'h0001; bus2.pad_in = 8'h42;
        wait_rsp(0, lat);
        check("read0001_latency", lat, 5);
        check("read0001_rdata", bus2.rsp_rdata, 8'h42);

        // WAIT_CYCLES=1: read 0x8000
        @(negedge clk);
        bus1.req_valid = 1; bus1.req_we = 0; bus1.req_addr = 16'h8000; bus1.pad_in = 8'hA5;
        wait_rsp(1, lat);
        check("w1_latency", lat, 4);
        check("w1_rdata", bus1.rsp_rdata, 8'hA5);

        // WAIT_CYCLES=15: read
        @(negedge clk);
        bus15.req_valid = 1; bus15.req_we = 0; bus15.req_addr = 16'h0F0F; bus15.pad_in = 8'h5A;
        wait_rsp(2, lat);
        check("w15_latency", lat, 18);
        check("w15_rdata", bus15.rsp_rdata, 8'h5A);

        // WAIT_CYCLES=3: load rsp_rdata, then reset in the middle of RWAIT
        @(negedge clk);
        bus3.req_valid = 1; bus3.req_we = 0; bus3.req_addr = 16'h0100; bus3.pad_in = 8'h99;
        wait_rsp(3, lat);
        check("w3_latency", lat, 6);
        check("w3_rdata", bus3.rsp_rdata, 8'h99);
        @(negedge clk);
        bus3.req_valid = 1; bus3.req_we = 0; bus3.req_addr = 16'h0200; bus3.pad_in = 8'h66;
        repeat (4) begin
            @(negedge clk);
            bus3.req_valid = 0;
        end
        check("w3_rwait_bus_off", {bus3.pad_oe, bus3.rsp_valid}, {8'h00, 1'b0});
        #2 rst = 1'b1;
        #1 check("w3_rst_rdata", {bus3.rsp_rdata, bus3.rsp_valid}, {8'h00, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        watch_quiet(3, "w3_rst_no_rsp");
        @(negedge clk);
        bus3.req_valid = 1; bus3.req_we = 1; bus3.req_addr = 16'h0300; bus3.req_wdata = 8'h3A;
        wait_rsp(3, lat);
        check("w3_write_latency", lat, 4);
        check("w3_write_rdata", bus3.rsp_rdata, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_sequencer.md
Name: mem_bus_sequencer

Overview:
Owns the shared 8-bit external memory pad bus for the SAP-3 core. It converts a single CPU-side memory request (16-bit address, read/write, 8-bit write data) into the pin-level sequence: address high byte, address low byte, then a data write or a turnaround-and-wait read. It drives the MAR/RAM write strobes and the per-pin output enables. It returns read data through a one-cycle response pulse. It sits between the core's memory request interface and the top-level uio pads, ui_in read path and strobe outputs.

Parameters:
WAIT_CYCLES, 2, cycles the bus is released before read data is sampled; legal range 1..15, elaboration error otherwise.

Ports:
clk  input  1  core clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present; must be held until accepted
req_ready  output  1  block can accept a request (IDLE only)
req_we  input  1  1 = write, 0 = read
req_addr  input  16  memory address
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle pulse: access complete
rsp_rdata  output  8  last read data; held between reads
pad_out  output  8  value driven onto the pad bus
pad_oe  output  8  per-bit output enable (1 = drive)
pad_in  input  8  pad bus read value
mar_we  output  1  external MAR byte latch strobe
addr_hi  output  1  1 = MAR byte is the high address byte
ram_we  output  1  external RAM write strobe

Behaviour:
- Reset (async on rst rising, held while high):
  - State = IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_rdata=0x00.
  - pad_out=0x00, pad_oe=0x00.
  - mar_we=0, addr_hi=0, ram_we=0.
  - Wait counter = 0.
  - Any in-flight access is dropped and produces no response.
- All outputs come from flops. Each output value is stable for the entire cycle spent in a state and changes only on a state-entry edge or on reset.
- Handshake and capture:
  - Accept occurs when req_valid && req_ready at a rising edge; call the cycle in which this happens cycle 0.
  - req_we, req_addr and req_wdata are captured at that edge. Later changes to them are ignored.
  - req_ready=1 only in IDLE. req_valid while busy is ignored without error.
- FSM states, with per-state outputs:
  - IDLE: req_ready=1; pad_oe=0x00, pad_out=0x00; all strobes 0.
  - ADDR_H (cycle 1): pad_out=addr[15:8], pad_oe=0xFF, mar_we=1, addr_hi=1.
  - ADDR_L (cycle 2): pad_out=addr[7:0], pad_oe=0xFF, mar_we=1, addr_hi=0. Next state is WRITE if we=1, else RWAIT.
  - WRITE (cycle 3): pad_out=wdata, pad_oe=0xFF, ram_we=1, mar_we=0. Next state is RESP.
  - RWAIT (cycles 3..2+WAIT_CYCLES):
    - pad_oe=0x00 and pad_out=0x00 from its first cycle (bus turnaround).
    - Counter is loaded with WAIT_CYCLES-1 on entry and decrements each cycle.
    - At the edge ending the cycle where counter==0, pad_in is sampled into rsp_rdata and the state becomes RESP.
  - RESP: rsp_valid=1 for exactly one cycle; pad_oe=0x00; strobes 0. Next state is IDLE. A write leaves rsp_rdata unchanged.
- Latency, measured from accept cycle 0:
  - Read: rsp_valid in cycle 3+WAIT_CYCLES; next accept possible in cycle 4+WAIT_CYCLES.
  - Write: rsp_valid in cycle 4; next accept possible in cycle 5.
- Invariants:
  - mar_we and ram_we are never high in the same cycle.
  - pad_oe is never 0xFF in the cycle directly after RWAIT ends.
  - No back-to-back accept without passing through IDLE.

Test Plan:
- Reset: assert rst during ADDR_L of a write → same-cycle (async) pad_oe=0x00, mar_we=0, req_ready=1. No rsp_valid ever follows. After release, a read to 0x0001 completes normally.
- Write 0x12AB ← 0x5C:
  - cycle1: pad_out 0x12, oe 0xFF, mar_we 1, addr_hi 1.
  - cycle2: pad_out 0xAB, addr_hi 0.
  - cycle3: pad_out 0x5C, ram_we 1, mar_we 0.
  - cycle4: rsp_valid 1, rsp_rdata unchanged.
  - cycle5: req_ready 1.
- Read 0x00F0, WAIT_CYCLES=2, pad_in 0xFF in cycle3 and 0x3C in cycle4:
  - pad_oe 0x00 in cycles 3–4.
  - cycle5: rsp_valid 1, rsp_rdata 0x3C.
  - rsp_rdata holds 0x3C after rsp_valid drops.
- Held req_valid with req_addr changed to 0xBEEF during busy:
  - The first access uses the captured address.
  - The second request is accepted only in the IDLE cycle after RESP and uses 0xBEEF.
  - req_ready=0 throughout cycles 1..RESP.
- WAIT_CYCLES=1: read of 0x8000 with pad_in=0xA5 → rsp_valid in cycle 4, rsp_rdata 0xA5. WAIT_CYCLES=15: rsp_valid in cycle 18.
- Async reset asserted mid-RWAIT (cycle 4, WAIT_CYCLES=3) → rsp_rdata reverts to 0x00 and rsp_valid stays 0. A subsequent write then completes in 4 cycles.
